irq_aggregator: RTL and testbench

- Memory-mapped interrupt aggregator between peripheral interrupt lines (timer, UART, GPIO, ...) and the core's single external interrupt input.
- Provides per-source synchronisation, edge/level gating, enable masking, and claim/complete handshake.
- Same single-cycle req / one-cycle rvalid bus protocol as the other system peripherals.
- Upper address bits are decoded outside the block into req.

---
 rtl/irq_aggregator_pkg.sv | 19 +
 rtl/irq_gateway.sv | 88 ++++++++
 rtl/irq_aggregator.sv | 120 ++++++++++++
 tb/tb_irq_aggregator.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/irq_aggregator_pkg.sv
// Shared constants and types for the interrupt aggregator: register offsets,
// gateway state encoding and the source-ID width.
package irq_aggregator_pkg;

  localparam int unsigned IdWidth = 5;

  localparam logic [7:0] OffPending  = 8'h00;
  localparam logic [7:0] OffEnable   = 8'h04;
  localparam logic [7:0] OffEdgeCfg  = 8'h08;
  localparam logic [7:0] OffClaim    = 8'h0C;
  localparam logic [7:0] OffComplete = 8'h10;

  typedef enum logic [1:0] {
    GwIdle      = 2'd0,
    GwPending   = 2'd1,
    GwInService = 2'd2
  } gw_state_e;

endpackage

// File: rtl/irq_gateway.sv
// Per-source gateway: 2-flop synchroniser, rising-edge detect and the
// IDLE / PENDING / IN_SERVICE state machine with a sticky re-pend flag.
module irq_gateway
  import irq_aggregator_pkg::*;
(
  input  logic      clk_i,
  input  logic      rst_ni,
  input  logic      src,
  input  logic      edge_mode,
  input  logic      claim_win,
  input  logic      complete_hit,
  output logic      pending,
  output gw_state_e state
);

  logic      sync_1, sync_q, sync_prev;
  logic [1:0] seen_q;
  logic      armed_q;
  logic      edge_det;
  logic      repend_q, repend_d;
  gw_state_e state_q, state_d;

  // seen_q marks when sync_q carries a real sample rather than its reset value,
  // so a line held high across reset must be observed low before it can edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_1    <= 1'b0;
      sync_q    <= 1'b0;
      sync_prev <= 1'b0;
      seen_q    <= '0;
      armed_q   <= 1'b0;
    end else begin
      sync_1    <= src;
      sync_q    <= sync_1;
      sync_prev <= sync_q;
      seen_q    <= {seen_q[0], 1'b1};
      armed_q   <= armed_q | (seen_q[1] & ~sync_q);
    end
  end

  assign edge_det = sync_q & ~sync_prev & armed_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= GwIdle;
      repend_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      repend_q <= repend_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    repend_d = repend_q;
    unique case (state_q)
      GwIdle: begin
        if (edge_mode ? edge_det : sync_q) state_d = GwPending;
      end
      GwPending: begin
        if (claim_win) begin
          state_d = GwInService;
          if (edge_mode && edge_det) repend_d = 1'b1;
        end else if (!edge_mode && !sync_q) begin
          state_d = GwIdle;
        end
      end
      GwInService: begin
        if (complete_hit) begin
          state_d  = (edge_mode && (repend_q || edge_det)) ? GwPending : GwIdle;
          repend_d = 1'b0;
        end else if (edge_mode && edge_det) begin
          repend_d = 1'b1;
        end
      end
      default: begin
        state_d  = GwIdle;
        repend_d = 1'b0;
      end
    endcase
  end

  always_comb begin
    pending = (state_q == GwPending);
    state   = state_q;
  end

endmodule

// File: rtl/irq_aggregator.sv
// Memory-mapped interrupt aggregator: bus decode, ENABLE/EDGE_CFG registers,
// lowest-ID claim arbitration and the registered interrupt to the core.
module irq_aggregator
  import irq_aggregator_pkg::*;
#(
  parameter int NumSrc       = 16,
  parameter int DataWidth    = 32,
  parameter int AddressWidth = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [NumSrc-1:0]       irq_src_i,
  input  logic                    irq_req_i,
  input  logic [AddressWidth-1:0] irq_addr_i,
  input  logic                    irq_we_i,
  input  logic [DataWidth/8-1:0]  irq_be_i,
  input  logic [DataWidth-1:0]    irq_wdata_i,
  output logic                    irq_rvalid_o,
  output logic [DataWidth-1:0]    irq_rdata_o,
  output logic                    irq_err_o,
  output logic                    irq_o
);

  if (DataWidth != 32) begin : g_bad_data_width
    $error("irq_aggregator: DataWidth must be 32");
  end
  if (NumSrc < 1 || NumSrc > 31) begin : g_bad_num_src
    $error("irq_aggregator: NumSrc must be in 1..31");
  end

  logic [7:0]         offset;
  logic               hit_pend, hit_en, hit_edge, hit_claim, hit_compl;
  logic               bus_err, wr_ok, claim_fire, complete_fire;
  logic [NumSrc-1:0]  enable_q, edge_cfg_q, pending, active, claim_win;
  logic [IdWidth-1:0] claim_id;
  logic [DataWidth-1:0] rd_val;
  gw_state_e [NumSrc-1:0] gw_state;
  logic               unused_dbg;

  assign offset    = irq_addr_i[7:0];
  assign hit_pend  = (offset == OffPending);
  assign hit_en    = (offset == OffEnable);
  assign hit_edge  = (offset == OffEdgeCfg);
  assign hit_claim = (offset == OffClaim);
  assign hit_compl = (offset == OffComplete);

  assign bus_err = ~(hit_pend | hit_en | hit_edge | hit_claim | hit_compl)
                 | (irq_we_i & (hit_pend | hit_claim))
                 | (~irq_we_i & hit_compl);

  // Partial-byte writes are silently dropped; they are not an error.
  assign wr_ok         = irq_req_i & irq_we_i & ~bus_err & (&irq_be_i);
  assign complete_fire = wr_ok & hit_compl;
  assign claim_fire    = irq_req_i & ~irq_we_i & hit_claim;

  assign active = pending & enable_q;

  always_comb begin
    claim_id = '0;
    for (int i = NumSrc - 1; i >= 0; i--) begin
      if (active[i]) claim_id = IdWidth'(i + 1);
    end
  end

  for (genvar i = 0; i < NumSrc; i++) begin : g_gw
    assign claim_win[i] = claim_fire & (claim_id == IdWidth'(i + 1));

    irq_gateway u_gateway (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .src          (irq_src_i[i]),
      .edge_mode    (edge_cfg_q[i]),
      .claim_win    (claim_win[i]),
      .complete_hit (complete_fire & (irq_wdata_i == DataWidth'(i + 1))),
      .pending      (pending[i]),
      .state        (gw_state[i])
    );
  end

  // Gateway states stay visible at this level for bound checkers.
  assign unused_dbg = ^{gw_state, irq_addr_i[AddressWidth-1:8]};

  always_comb begin
    rd_val = '0;
    case (offset)
      OffPending: rd_val = {{(DataWidth-NumSrc){1'b0}}, pending};
      OffEnable:  rd_val = {{(DataWidth-NumSrc){1'b0}}, enable_q};
      OffEdgeCfg: rd_val = {{(DataWidth-NumSrc){1'b0}}, edge_cfg_q};
      OffClaim:   rd_val = {{(DataWidth-IdWidth){1'b0}}, claim_id};
      default:    rd_val = '0;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      enable_q   <= '0;
      edge_cfg_q <= '0;
    end else if (wr_ok) begin
      if (hit_en)   enable_q   <= irq_wdata_i[NumSrc-1:0];
      if (hit_edge) edge_cfg_q <= irq_wdata_i[NumSrc-1:0];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      irq_rvalid_o <= 1'b0;
      irq_rdata_o  <= '0;
      irq_err_o    <= 1'b0;
      irq_o        <= 1'b0;
    end else begin
      irq_rvalid_o <= irq_req_i;
      irq_o        <= |active;
      if (irq_req_i) begin
        irq_err_o   <= bus_err;
        irq_rdata_o <= (bus_err || irq_we_i) ? '0 : rd_val;
      end
    end
  end

endmodule

// File: tb/tb_irq_aggregator.sv
// Directed bench for irq_aggregator: hand-computed register values, claim
// order, edge re-pend, bus errors, back-to-back access and reset behaviour.
module tb_irq_aggregator;

  localparam int NumSrc = 16;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic [15:0] irq_src_i = '0;
  logic        irq_req_i = 1'b0;
  logic [31:0] irq_addr_i = '0;
  logic        irq_we_i = 1'b0;
  logic [3:0]  irq_be_i = '0;
  logic [31:0] irq_wdata_i = '0;
  logic        irq_rvalid_o;
  logic [31:0] irq_rdata_o;
  logic        irq_err_o;
  logic        irq_o;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] exp_q[$];

  irq_aggregator #(.NumSrc(NumSrc), .DataWidth(32), .AddressWidth(32)) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .irq_src_i    (irq_src_i),
    .irq_req_i    (irq_req_i),
    .irq_addr_i   (irq_addr_i),
    .irq_we_i     (irq_we_i),
    .irq_be_i     (irq_be_i),
    .irq_wdata_i  (irq_wdata_i),
    .irq_rvalid_o (irq_rvalid_o),
    .irq_rdata_o  (irq_rdata_o),
    .irq_err_o    (irq_err_o),
    .irq_o        (irq_o)
  );

  // clock / reset
  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  // driver tasks: called 1ns after a rising edge, return 1ns after the next one
  task automatic bus(input logic we, input logic [7:0] addr, input logic [3:0] be,
                     input logic [31:0] wdata, output logic [31:0] rdata, output logic err);
    irq_req_i   = 1'b1;
    irq_we_i    = we;
    irq_addr_i  = {24'h0, addr};
    irq_be_i    = be;
    irq_wdata_i = wdata;
    @(posedge clk_i);
    #1;
    irq_req_i = 1'b0;
    irq_we_i  = 1'b0;
    rdata = irq_rdata_o;
    err   = irq_err_o;
    check("rvalid", {31'b0, irq_rvalid_o}, 32'd1);
  endtask

  task automatic rd(input string tag, input logic [7:0] addr, input logic [31:0] exp);
    logic [31:0] d;
    logic        e;
    bus(1'b0, addr, 4'hF, 32'h0, d, e);
    check(tag, d, exp);
    check({tag, "_err"}, {31'b0, e}, 32'd0);
  endtask

  task automatic wr(input string tag, input logic [7:0] addr, input logic [31:0] data,
                    input logic [3:0] be, input logic exp_err);
    logic [31:0] d;
    logic        e;
    bus(1'b1, addr, be, data, d, e);
    check({tag, "_err"}, {31'b0, e}, {31'b0, exp_err});
  endtask

  task automatic pulse_src(input int idx);
    irq_src_i[idx] = 1'b1;
    cycles(2);
    irq_src_i[idx] = 1'b0;
    cycles(2);
  endtask

  initial begin
    logic [31:0] d;
    logic        e;

    #12;
    check("rst_irq", {31'b0, irq_o}, 32'd0);
    check("rst_rvalid", {31'b0, irq_rvalid_o}, 32'd0);
    check("rst_rdata", irq_rdata_o, 32'd0);
    check("rst_err", {31'b0, irq_err_o}, 32'd0);
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    rd("rst_enable", 8'h04, 32'h0);
    rd("rst_edge", 8'h08, 32'h0);

    // level source 1: 4-cycle latency, claim, complete
    wr("en1", 8'h04, 32'h1, 4'hF, 1'b0);
    irq_src_i[0] = 1'b1;
    cycles(3);
    check("lat_3", {31'b0, irq_o}, 32'd0);
    cycles(1);
    check("lat_4", {31'b0, irq_o}, 32'd1);
    rd("claim1", 8'h0C, 32'd1);
    cycles(1);
    check("irq_after_claim", {31'b0, irq_o}, 32'd0);
    irq_src_i[0] = 1'b0;
    cycles(3);
    rd("pend_insvc", 8'h00, 32'h0);
    wr("compl1", 8'h10, 32'd1, 4'hF, 1'b0);
    rd("pend_after_compl", 8'h00, 32'h0);

    // sources 3 and 5: lowest ID first, then 0 with no side effect
    irq_src_i[2] = 1'b1;
    irq_src_i[4] = 1'b1;
    wr("en14", 8'h04, 32'h14, 4'hF, 1'b0);
    cycles(3);
    rd("pend35", 8'h00, 32'h14);
    rd("claim3", 8'h0C, 32'd3);
    rd("claim5", 8'h0C, 32'd5);
    rd("claim0", 8'h0C, 32'd0);
    rd("pend35_after", 8'h00, 32'h0);
    check("irq35_low", {31'b0, irq_o}, 32'd0);
    irq_src_i[2] = 1'b0;
    irq_src_i[4] = 1'b0;
    cycles(3);
    wr("compl3", 8'h10, 32'd3, 4'hF, 1'b0);
    wr("compl5", 8'h10, 32'd5, 4'hF, 1'b0);
    rd("pend35_done", 8'h00, 32'h0);

    // edge source 2 pulsed twice while in service re-pends exactly once
    wr("edge2", 8'h08, 32'h2, 4'hF, 1'b0);
    wr("en2", 8'h04, 32'h2, 4'hF, 1'b0);
    pulse_src(1);
    rd("pend2", 8'h00, 32'h2);
    rd("claim2", 8'h0C, 32'd2);
    pulse_src(1);
    pulse_src(1);
    cycles(3);
    rd("pend2_insvc", 8'h00, 32'h0);
    wr("compl2a", 8'h10, 32'd2, 4'hF, 1'b0);
    rd("pend2_repend", 8'h00, 32'h2);
    rd("claim2b", 8'h0C, 32'd2);
    rd("claim2c", 8'h0C, 32'd0);
    wr("compl2b", 8'h10, 32'd2, 4'hF, 1'b0);
    rd("pend2_done", 8'h00, 32'h0);

    // register access rules and error responses
    wr("en_partial", 8'h04, 32'hFFFF, 4'b0011, 1'b0);
    rd("en_unchanged", 8'h04, 32'h2);
    bus(1'b0, 8'h14, 4'hF, 32'h0, d, e);
    check("unmapped_err", {31'b0, e}, 32'd1);
    check("unmapped_rdata", d, 32'h0);
    wr("wr_pending", 8'h00, 32'hFFFF, 4'hF, 1'b1);
    wr("wr_claim", 8'h0C, 32'h1, 4'hF, 1'b1);
    bus(1'b0, 8'h10, 4'hF, 32'h0, d, e);
    check("rd_compl_err", {31'b0, e}, 32'd1);
    check("rd_compl_rdata", d, 32'h0);
    wr("compl_zero", 8'h10, 32'd0, 4'hF, 1'b0);
    wr("compl_big", 8'h10, 32'd17, 4'hF, 1'b0);
    wr("en_all", 8'h04, 32'hFFFF_FFFF, 4'hF, 1'b0);
    rd("en_masked", 8'h04, 32'h0000_FFFF);
    rd("edge_cfg", 8'h08, 32'h2);

    // back-to-back reads on consecutive cycles
    wr("en_a5", 8'h04, 32'hA5, 4'hF, 1'b0);
    wr("edge_3", 8'h08, 32'h3, 4'hF, 1'b0);
    exp_q.push_back(32'hA5);
    exp_q.push_back(32'h3);
    irq_req_i  = 1'b1;
    irq_we_i   = 1'b0;
    irq_be_i   = 4'hF;
    irq_addr_i = 32'h04;
    @(posedge clk_i);
    #1;
    check("b2b_rvalid0", {31'b0, irq_rvalid_o}, 32'd1);
    check("b2b_rdata0", irq_rdata_o, exp_q.pop_front());
    irq_addr_i = 32'h08;
    @(posedge clk_i);
    #1;
    irq_req_i = 1'b0;
    check("b2b_rvalid1", {31'b0, irq_rvalid_o}, 32'd1);
    check("b2b_rdata1", irq_rdata_o, exp_q.pop_front());
    cycles(1);
    check("b2b_idle", {31'b0, irq_o | irq_rvalid_o}, 32'd0);
    wr("edge_0", 8'h08, 32'h0, 4'hF, 1'b0);

    // reset while source 1 in service and source 3 pending
    wr("en5", 8'h04, 32'h5, 4'hF, 1'b0);
    irq_src_i[0] = 1'b1;
    irq_src_i[2] = 1'b1;
    cycles(3);
    rd("claim_pre_rst", 8'h0C, 32'd1);
    cycles(1);
    check("irq_pre_rst", {31'b0, irq_o}, 32'd1);
    #3;
    rst_ni = 1'b0;
    #1;
    check("irq_in_rst", {31'b0, irq_o}, 32'd0);
    check("rvalid_in_rst", {31'b0, irq_rvalid_o}, 32'd0);
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    cycles(2);
    rd("level_repend_c3", 8'h00, 32'h0);
    rd("level_repend_c4", 8'h00, 32'h5);

    // same line as edge source after reset: needs a low-then-high transition
    irq_src_i[2] = 1'b0;
    #3;
    rst_ni = 1'b0;
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    wr("edge1_cfg", 8'h08, 32'h1, 4'hF, 1'b0);
    wr("edge1_en", 8'h04, 32'h1, 4'hF, 1'b0);
    cycles(4);
    rd("edge_held_high", 8'h00, 32'h0);
    check("edge_held_irq", {31'b0, irq_o}, 32'd0);
    irq_src_i[0] = 1'b0;
    cycles(3);
    irq_src_i[0] = 1'b1;
    cycles(4);
    check("edge_rise_irq", {31'b0, irq_o}, 32'd1);
    rd("edge_rise_pend", 8'h00, 32'h1);
    rd("edge_claim", 8'h0C, 32'd1);
    wr("edge_compl", 8'h10, 32'd1, 4'hF, 1'b0);
    rd("edge_done", 8'h00, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
